// File: rtl/mon_pkg.sv
// Shared definitions for the Montgomery exponentiation datapath (mon_prep, mon_exp).
package mon_pkg;

  localparam int unsigned BitLenDef = 1024;
  localparam int unsigned CntLenDef = 11;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } mon_state_e;

endpackage

// File: rtl/mod_dbl.sv
// Combinational modular doubling: dbl_o = 2*r_i mod n_i, valid for r_i < n_i.
module mod_dbl #(
  parameter int unsigned Width = 1024
) (
  input  logic [Width:0]   r_i,
  input  logic [Width-1:0] n_i,
  output logic [Width:0]   dbl_o
);

  logic [Width+1:0] twice;
  logic [Width+1:0] n_ext;
  logic             ge;

  assign twice = {r_i, 1'b0};
  assign n_ext = {2'b00, n_i};
  assign ge    = (twice >= n_ext);
  // r < n guarantees 2r - n < n, so the result always fits in Width+1 bits
  assign dbl_o = (Width+1)'(ge ? (twice - n_ext) : twice);

endmodule

// File: rtl/mon_prep.sv
// Operand conditioning for mon_exp: M_bar = M*2^k mod n, x_bar = 2^k mod n, e_idx = bitlen(e).
// Optional operand range checking is enabled by defining MON_PREP_RANGE_CHK_EN.
module mon_prep
  import mon_pkg::*;
#(
  parameter int unsigned bitLen = BitLenDef,
  parameter int unsigned cntLen = CntLenDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [bitLen-1:0] M,
  input  logic [bitLen-1:0] n,
  input  logic [bitLen-1:0] e,
  input  logic [cntLen-1:0] mp_count,
  output logic [bitLen-1:0] M_bar,
  output logic [bitLen-1:0] x_bar,
  output logic [cntLen-1:0] e_idx,
  output logic              stop,
  output logic              err
);

  mon_state_e        state_q, state_d;
  logic [cntLen-1:0] cnt_q, cnt_d;
  logic [bitLen:0]   rm_q, rm_d;
  logic [bitLen:0]   rx_q, rx_d;
  logic [bitLen-1:0] n_q, n_d;
  logic [cntLen-1:0] e_idx_q, e_idx_d;
  logic [bitLen-1:0] m_bar_q;
  logic [bitLen-1:0] x_bar_q;
  logic              stop_q;
  logic [cntLen-1:0] e_enc;
  logic [bitLen:0]   rm_dbl;
  logic [bitLen:0]   rx_dbl;

  // Bit length of e: index of the highest set bit plus one
  always_comb begin
    e_enc = '0;
    for (int i = 0; i < bitLen; i++) begin
      if (e[i]) e_enc = cntLen'(i + 1);
    end
  end

  mod_dbl #(
    .Width(bitLen)
  ) u_dbl_m (
    .r_i  (rm_q),
    .n_i  (n_q),
    .dbl_o(rm_dbl)
  );

  mod_dbl #(
    .Width(bitLen)
  ) u_dbl_x (
    .r_i  (rx_q),
    .n_i  (n_q),
    .dbl_o(rx_dbl)
  );

`ifdef MON_PREP_RANGE_CHK_EN
  logic bad_q, bad_d;
  logic bad_in;
  logic err_q;

  assign bad_in = (M >= n) || !n[0] || (n < bitLen'(3));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rm_d    = rm_q;
    rx_d    = rx_q;
    n_d     = n_q;
    e_idx_d = e_idx_q;
`ifdef MON_PREP_RANGE_CHK_EN
    bad_d   = bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = n;
          e_idx_d = e_enc;
          cnt_d   = mp_count;
          rm_d    = {1'b0, M};
          rx_d    = (bitLen+1)'(1);
          state_d = (mp_count == '0) ? StDone : StShift;
`ifdef MON_PREP_RANGE_CHK_EN
          bad_d   = 1'b0;
          if (bad_in) begin
            rm_d    = '0;
            rx_d    = '0;
            bad_d   = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StShift: begin
        rm_d  = rm_dbl;
        rx_d  = rx_dbl;
        cnt_d = cnt_q - cntLen'(1);
        if (cnt_q == cntLen'(1)) state_d = StDone;
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rm_q    <= '0;
      rx_q    <= '0;
      n_q     <= '0;
      e_idx_q <= '0;
      m_bar_q <= '0;
      x_bar_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rm_q    <= rm_d;
      rx_q    <= rx_d;
      n_q     <= n_d;
      e_idx_q <= e_idx_d;
      // stop tracks start so it drops on the same edge the FSM returns to idle
      stop_q  <= (state_q == StDone) && start;
      if (state_q == StDone) begin
        m_bar_q <= rm_q[bitLen-1:0];
        x_bar_q <= rx_q[bitLen-1:0];
      end
    end
  end

`ifdef MON_PREP_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
      err_q <= (state_q == StDone) && start && bad_q;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign M_bar = m_bar_q;
  assign x_bar = x_bar_q;
  assign e_idx = e_idx_q;
  assign stop  = stop_q;

endmodule

// File: tb/tb_mon_prep.sv
// Scoreboard bench for mon_prep on a narrow datapath; expected values come from 64-bit arithmetic.
module tb_mon_prep;

  localparam int unsigned BL = 16;
  localparam int unsigned CL = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [BL-1:0] M, n, e;
  logic [CL-1:0] mp_count;
  logic [BL-1:0] M_bar, x_bar;
  logic [CL-1:0] e_idx;
  logic          stop, err;

  typedef struct {
    logic [BL-1:0] m_bar;
    logic [BL-1:0] x_bar;
    logic [CL-1:0] e_idx;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  mon_prep #(
    .bitLen(BL),
    .cntLen(CL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .M       (M),
    .n       (n),
    .e       (e),
    .mp_count(mp_count),
    .M_bar   (M_bar),
    .x_bar   (x_bar),
    .e_idx   (e_idx),
    .stop    (stop),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input longint unsigned m_v, input longint unsigned n_v,
                                 input longint unsigned e_v, input int k);
    exp_t r;
    longint unsigned p;
    p       = 64'd1 << k;
    r.m_bar = BL'((m_v * p) % n_v);
    r.x_bar = BL'(p % n_v);
    r.e_idx = CL'($clog2(e_v + 1));
    r.err   = 1'b0;
    r.lat   = k + 2;  // edges counted from the accepting edge through the edge raising stop
`ifdef MON_PREP_RANGE_CHK_EN
    if (m_v >= n_v || (n_v % 2) == 0 || n_v < 3) begin
      r.m_bar = '0;
      r.x_bar = '0;
      r.err   = 1'b1;
      r.lat   = 2;
    end
`endif
    return r;
  endfunction

  task automatic issue(input int m_v, input int n_v, input int e_v, input int k);
    M        = BL'(m_v);
    n        = BL'(n_v);
    e        = BL'(e_v);
    mp_count = CL'(k);
    start    = 1'b1;
    sb.push_back(model(longint'(m_v), longint'(n_v), longint'(e_v), k));
  endtask

  task automatic wait_stop(input bit scramble, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (scramble && cyc == 1) begin
        M        = BL'($urandom);
        n        = BL'($urandom);
        e        = BL'($urandom);
        mp_count = CL'($urandom);
      end
      if (stop) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drop;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    M = '0; n = '0; e = '0; mp_count = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({stop, err, M_bar, x_bar, e_idx} !== '0)
      $display("FAIL reset_outputs: got stop=%0b err=%0b M_bar=%0d x_bar=%0d e_idx=%0d, want all 0",
               stop, err, M_bar, x_bar, e_idx);
    else passed++;
  endtask

  task automatic test_vectors;
    int m_t[3] = '{311, 1, 5};
    int n_t[3] = '{589, 589, 7};
    int e_t[3] = '{300, 0, 1};
    int k_t[3] = '{10, 10, 0};
    int cyc;
    bit ok;
    exp_t x;
    for (int t = 0; t < 3; t++) begin
      issue(m_t[t], n_t[t], e_t[t], k_t[t]);
      wait_stop(t == 0, cyc, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || cyc != x.lat) $display("FAIL vec%0d_latency: got %0d edges ok=%0b, want %0d", t, cyc, ok, x.lat);
      else passed++;
      checks++;
      if (M_bar !== x.m_bar) $display("FAIL vec%0d_M_bar: got %0d, want %0d", t, M_bar, x.m_bar);
      else passed++;
      checks++;
      if (x_bar !== x.x_bar) $display("FAIL vec%0d_x_bar: got %0d, want %0d", t, x_bar, x.x_bar);
      else passed++;
      checks++;
      if (e_idx !== x.e_idx) $display("FAIL vec%0d_e_idx: got %0d, want %0d", t, e_idx, x.e_idx);
      else passed++;
      checks++;
      if (err !== x.err) $display("FAIL vec%0d_err: got %0b, want %0b", t, err, x.err);
      else passed++;
      drop();
    end
    // Spec constants cross-check the model itself
    checks++;
    if (model(311, 589, 300, 10).m_bar !== BL'(404) || model(311, 589, 300, 10).x_bar !== BL'(435))
      $display("FAIL model_const: got %0d/%0d, want 404/435", model(311, 589, 300, 10).m_bar,
               model(311, 589, 300, 10).x_bar);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit ok;
    exp_t x;
    issue(311, 589, 300, 10);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({stop, err, M_bar, x_bar, e_idx} !== '0)
      $display("FAIL reset_mid_outputs: got stop=%0b err=%0b M_bar=%0d x_bar=%0d e_idx=%0d, want all 0",
               stop, err, M_bar, x_bar, e_idx);
    else passed++;
    sb.delete();
    reset = 1'b0;
    issue(311, 589, 300, 10);
    wait_stop(1'b0, cyc, ok);
    x = sb.pop_front();
    checks++;
    if (!ok || cyc != x.lat) $display("FAIL reset_mid_latency: got %0d ok=%0b, want %0d", cyc, ok, x.lat);
    else passed++;
    checks++;
    if (M_bar !== x.m_bar || x_bar !== x.x_bar)
      $display("FAIL reset_mid_result: got %0d/%0d, want %0d/%0d", M_bar, x_bar, x.m_bar, x.x_bar);
    else passed++;
  endtask

  task automatic test_hold;
    int cyc;
    bit ok;
    exp_t x;
    int bad = 0;
    // Previous task left start high in DONE
    x = model(311, 589, 300, 10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!stop || M_bar !== x.m_bar || x_bar !== x.x_bar || e_idx !== x.e_idx) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL hold_stable: got %0d unstable cycles, want 0", bad);
    else passed++;
    drop();
    checks++;
    if (stop !== 1'b0) $display("FAIL hold_drop_stop: got %0b, want 0", stop);
    else passed++;
    issue(101, 1023, 65535, 7);
    wait_stop(1'b0, cyc, ok);
    x = sb.pop_front();
    checks++;
    if (!ok || cyc != x.lat) $display("FAIL back_to_back_latency: got %0d ok=%0b, want %0d", cyc, ok, x.lat);
    else passed++;
    checks++;
    if (M_bar !== x.m_bar || x_bar !== x.x_bar || e_idx !== x.e_idx)
      $display("FAIL back_to_back_result: got %0d/%0d/%0d, want %0d/%0d/%0d",
               M_bar, x_bar, e_idx, x.m_bar, x.x_bar, x.e_idx);
    else passed++;
    drop();
  endtask

  task automatic test_random;
    int cyc;
    bit ok;
    exp_t x;
    int nv, mv;
    for (int t = 0; t < 12; t++) begin
      nv = int'($urandom_range(65535, 3)) | 1;
      mv = int'($urandom_range(nv - 1, 0));
      issue(mv, nv, int'($urandom_range(65535, 0)), int'($urandom_range(31, 0)));
      wait_stop(1'b1, cyc, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || cyc != x.lat || M_bar !== x.m_bar || x_bar !== x.x_bar || e_idx !== x.e_idx
          || err !== x.err)
        $display("FAIL rand%0d: got lat=%0d M_bar=%0d x_bar=%0d e_idx=%0d err=%0b, want %0d %0d %0d %0d %0b",
                 t, cyc, M_bar, x_bar, e_idx, err, x.lat, x.m_bar, x.x_bar, x.e_idx, x.err);
      else passed++;
      drop();
    end
  endtask

  task automatic test_range;
    int cyc;
    bit ok;
    exp_t x;
    int m_t[2] = '{600, 5};
    int n_t[2] = '{589, 588};
    for (int t = 0; t < 2; t++) begin
      issue(m_t[t], n_t[t], 300, 10);
      wait_stop(1'b0, cyc, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || cyc != x.lat) $display("FAIL range%0d_latency: got %0d ok=%0b, want %0d", t, cyc, ok, x.lat);
      else passed++;
      checks++;
      if (err !== x.err) $display("FAIL range%0d_err: got %0b, want %0b", t, err, x.err);
      else passed++;
      checks++;
      if (x.err && (M_bar !== '0 || x_bar !== '0))
        $display("FAIL range%0d_zero: got %0d/%0d, want 0/0", t, M_bar, x_bar);
      else passed++;
      checks++;
      if (e_idx !== x.e_idx) $display("FAIL range%0d_e_idx: got %0d, want %0d", t, e_idx, x.e_idx);
      else passed++;
      drop();
      checks++;
      if (err !== 1'b0) $display("FAIL range%0d_err_clear: got %0b, want 0", t, err);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_reset_mid();
    test_hold();
    test_random();
    test_range();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
